// File: rtl/hazard_scoreboard.sv
// Hazard unit for the five-stage pipeline: EX operand forwarding, load-use stall, branch flush,
// and a per-register pending scoreboard with a watchdog for multi-cycle execute ops.
module hazard_scoreboard #(
  parameter int unsigned NREGS    = 32,
  parameter int unsigned REGW     = 5,
  parameter int unsigned MC_UNITS = 1,
  parameter int unsigned MAX_LAT  = 64,
  parameter int unsigned CNTW     = $clog2(MAX_LAT + 1)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  // Decode stage
  input  logic [REGW-1:0]                   Rs1D,
  input  logic [REGW-1:0]                   Rs2D,
  input  logic [REGW-1:0]                   RdD,
  input  logic                              mcD,
  // Execute stage
  input  logic [REGW-1:0]                   Rs1E,
  input  logic [REGW-1:0]                   Rs2E,
  input  logic [REGW-1:0]                   RdE,
  input  logic                              ResultSrcE_zero,
  input  logic                              PCSrcE,
  // Memory / writeback stages
  input  logic [REGW-1:0]                   RdM,
  input  logic [REGW-1:0]                   RdW,
  input  logic                              RegWriteM,
  input  logic                              RegWriteW,
  // Multi-cycle unit handshake
  input  logic                              mc_issue,
  input  logic [REGW-1:0]                   mc_issue_rd,
  input  logic                              mc_done,
  input  logic [REGW-1:0]                   mc_done_rd,
  // Pipeline controls
  output logic                              StallF,
  output logic                              StallD,
  output logic                              FlushD,
  output logic                              FlushE,
  output logic [1:0]                        ForwardAE,
  output logic [1:0]                        ForwardBE,
  // Scoreboard status
  output logic [NREGS-1:0]                  pending,
  output logic [$clog2(MC_UNITS+1)-1:0]     mc_inflight,
  output logic                              mc_timeout
);

  localparam int unsigned IFW = $clog2(MC_UNITS + 1);
  localparam logic [IFW-1:0]  InflMax = IFW'(MC_UNITS);
  localparam logic [CNTW-1:0] WdLimit = CNTW'(MAX_LAT);

  logic [NREGS-1:0] pendingQ, pendingD;
  logic [IFW-1:0]   inflightQ, inflightD;
  logic [CNTW-1:0]  wdCntQ, wdCntD;
  logic             timeoutQ, timeoutD;
  logic             protoErr;

  logic lwStall, sbStall;
  logic rawHaz, wawHaz, structHaz;

  // Newest producer (M) wins over older (W); x0 is hardwired zero and never forwarded.
  function automatic logic [1:0] fwdSel(input logic [REGW-1:0] rs,
                                        input logic [REGW-1:0] rdM,
                                        input logic            weM,
                                        input logic [REGW-1:0] rdW,
                                        input logic            weW);
    logic [1:0] sel;
    sel = 2'b00;
    if (rs != '0) begin
      if (weM && (rs == rdM)) begin
        sel = 2'b10;
      end else if (weW && (rs == rdW)) begin
        sel = 2'b01;
      end
    end
    return sel;
  endfunction

  always_comb begin
    ForwardAE = fwdSel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
    ForwardBE = fwdSel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
  end

  // Hazard detection
  always_comb begin
    lwStall   = ResultSrcE_zero && (RdE != '0) && ((Rs1D == RdE) || (Rs2D == RdE));
    rawHaz    = pendingQ[Rs1D] || pendingQ[Rs2D];
    wawHaz    = (RdD != '0) && pendingQ[RdD];
    // A completing op frees its unit this cycle, so a new one may follow right behind.
    structHaz = mcD && (inflightQ == InflMax) && !mc_done;
    sbStall   = rawHaz || wawHaz || structHaz;
  end

  always_comb begin
    StallF = lwStall || sbStall;
    StallD = lwStall || sbStall;
    FlushD = PCSrcE;
    FlushE = lwStall || sbStall || PCSrcE;
  end

  // Scoreboard: clear on completion first so a same-register issue re-sets the bit.
  always_comb begin
    pendingD = pendingQ;
    if (mc_done) begin
      pendingD[mc_done_rd] = 1'b0;
    end
    if (mc_issue && (mc_issue_rd != '0)) begin
      pendingD[mc_issue_rd] = 1'b1;
    end
    pendingD[0] = 1'b0;
  end

  // Outstanding op counter; attempts past either bound are protocol errors.
  always_comb begin
    inflightD = inflightQ;
    protoErr  = 1'b0;
    case ({mc_issue, mc_done})
      2'b10: begin
        if (inflightQ == InflMax) begin
          protoErr = 1'b1;
        end else begin
          inflightD = inflightQ + 1'b1;
        end
      end
      2'b01: begin
        if (inflightQ == '0) begin
          protoErr = 1'b1;
        end else begin
          inflightD = inflightQ - 1'b1;
        end
      end
      default: begin
        inflightD = inflightQ;
      end
    endcase
  end

  // Watchdog measures cycles without forward progress while ops are outstanding.
  always_comb begin
    wdCntD = wdCntQ;
    if (mc_done || (inflightQ == '0)) begin
      wdCntD = '0;
    end else if (wdCntQ != WdLimit) begin
      wdCntD = wdCntQ + 1'b1;
    end
    timeoutD = timeoutQ || protoErr || (wdCntD == WdLimit);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pendingQ  <= '0;
      inflightQ <= '0;
      wdCntQ    <= '0;
      timeoutQ  <= 1'b0;
    end else begin
      pendingQ  <= pendingD;
      inflightQ <= inflightD;
      wdCntQ    <= wdCntD;
      timeoutQ  <= timeoutD;
    end
  end

  assign pending     = pendingQ;
  assign mc_inflight = inflightQ;
  assign mc_timeout  = timeoutQ;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomised and directed bench for hazard_scoreboard against a behavioural model of the
// pipeline hazard rules and the multi-cycle op bookkeeping.
module tb_hazard_scoreboard;

  localparam int NR   = 32;
  localparam int RW   = 5;
  localparam int MC   = 1;
  localparam int ML   = 8;
  localparam int IFW  = $clog2(MC + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic [RW-1:0] Rs1D, Rs2D, RdD, Rs1E, Rs2E, RdE, RdM, RdW, mc_issue_rd, mc_done_rd;
  logic          mcD, ResultSrcE_zero, PCSrcE, RegWriteM, RegWriteW, mc_issue, mc_done;
  logic          StallF, StallD, FlushD, FlushE, mc_timeout;
  logic [1:0]    ForwardAE, ForwardBE;
  logic [NR-1:0] pending;
  logic [IFW-1:0] mc_inflight;

  hazard_scoreboard #(
    .NREGS   (NR),
    .REGW    (RW),
    .MC_UNITS(MC),
    .MAX_LAT (ML)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .Rs1D           (Rs1D),
    .Rs2D           (Rs2D),
    .RdD            (RdD),
    .mcD            (mcD),
    .Rs1E           (Rs1E),
    .Rs2E           (Rs2E),
    .RdE            (RdE),
    .ResultSrcE_zero(ResultSrcE_zero),
    .PCSrcE         (PCSrcE),
    .RdM            (RdM),
    .RdW            (RdW),
    .RegWriteM      (RegWriteM),
    .RegWriteW      (RegWriteW),
    .mc_issue       (mc_issue),
    .mc_issue_rd    (mc_issue_rd),
    .mc_done        (mc_done),
    .mc_done_rd     (mc_done_rd),
    .StallF         (StallF),
    .StallD         (StallD),
    .FlushD         (FlushD),
    .FlushE         (FlushE),
    .ForwardAE      (ForwardAE),
    .ForwardBE      (ForwardBE),
    .pending        (pending),
    .mc_inflight    (mc_inflight),
    .mc_timeout     (mc_timeout)
  );

  always #5 clk = ~clk;

  int unsigned nVec  = 0;
  int unsigned nMiss = 0;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nVec++;
    if (got !== exp) begin
      nMiss++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: set of busy registers, list of ops in flight, idle-progress age.
  bit mPend[NR];
  int mInfl;
  int mAge;
  bit mTo;
  int mQ[$];

  task automatic modelReset();
    foreach (mPend[i]) mPend[i] = 1'b0;
    mInfl = 0;
    mAge  = 0;
    mTo   = 1'b0;
    mQ.delete();
  endtask

  function automatic logic [1:0] expFwd(input int rs);
    if (rs != 0 && rs == int'(RdM) && RegWriteM) return 2'b10;
    if (rs != 0 && rs == int'(RdW) && RegWriteW) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit expStall();
    bit lw, sb;
    lw = ResultSrcE_zero && RdE != 0 && (Rs1D == RdE || Rs2D == RdE);
    sb = mPend[Rs1D] || mPend[Rs2D] || (RdD != 0 && mPend[RdD]) ||
         (mcD && mInfl == MC && !mc_done);
    return lw || sb;
  endfunction

  function automatic logic [NR-1:0] expPending();
    logic [NR-1:0] v;
    for (int i = 0; i < NR; i++) v[i] = mPend[i];
    return v;
  endfunction

  task automatic compareAll();
    bit st;
    st = expStall();
    checkVal("ForwardAE", 64'(ForwardAE), 64'(expFwd(int'(Rs1E))));
    checkVal("ForwardBE", 64'(ForwardBE), 64'(expFwd(int'(Rs2E))));
    checkVal("StallF", 64'(StallF), 64'(st));
    checkVal("StallD", 64'(StallD), 64'(st));
    checkVal("FlushD", 64'(FlushD), 64'(PCSrcE));
    checkVal("FlushE", 64'(FlushE), 64'(st || PCSrcE));
    checkVal("pending", 64'(pending), 64'(expPending()));
    checkVal("mc_inflight", 64'(mc_inflight), 64'(mInfl));
    checkVal("mc_timeout", 64'(mc_timeout), 64'(mTo));
  endtask

  task automatic modelStep();
    int oldInfl;
    oldInfl = mInfl;
    if (mc_done) mPend[mc_done_rd] = 1'b0;
    if (mc_issue && mc_issue_rd != 0) mPend[mc_issue_rd] = 1'b1;
    if (mc_issue && !mc_done) begin
      if (mInfl == MC) mTo = 1'b1;
      else mInfl++;
    end else if (mc_done && !mc_issue) begin
      if (mInfl == 0) mTo = 1'b1;
      else mInfl--;
    end
    // Age counts cycles an op has waited with no completion in between.
    if (mc_done || oldInfl == 0) mAge = 0;
    else if (mAge < ML) mAge++;
    if (mAge == ML) mTo = 1'b1;
    if (mc_done && mQ.size() > 0) void'(mQ.pop_front());
    if (mc_issue && mQ.size() < MC) mQ.push_back(int'(mc_issue_rd));
  endtask

  // Caller sets inputs just after a rising edge; this checks at the falling edge and advances.
  task automatic cycle();
    @(negedge clk);
    compareAll();
    modelStep();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    {Rs1D, Rs2D, RdD, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
    {mc_issue_rd, mc_done_rd} = '0;
    {mcD, ResultSrcE_zero, PCSrcE, RegWriteM, RegWriteW, mc_issue, mc_done} = '0;
  endtask

  task automatic randomPhase(input int n, input bit legalOnly);
    for (int c = 0; c < n; c++) begin
      Rs1D = RW'($urandom_range(0, 7));
      Rs2D = RW'($urandom_range(0, 7));
      RdD  = RW'($urandom_range(0, 7));
      Rs1E = RW'($urandom_range(0, 7));
      Rs2E = RW'($urandom_range(0, 7));
      RdE  = RW'($urandom_range(0, 7));
      RdM  = RW'($urandom_range(0, 7));
      RdW  = RW'($urandom_range(0, 7));
      mcD             = ($urandom % 3) == 0;
      ResultSrcE_zero = ($urandom % 3) == 0;
      PCSrcE          = ($urandom % 5) == 0;
      RegWriteM       = ($urandom % 2) == 0;
      RegWriteW       = ($urandom % 2) == 0;
      mc_done    = 1'b0;
      mc_done_rd = RW'($urandom_range(0, 7));
      if (mQ.size() > 0 && ($urandom % 3) == 0) begin
        mc_done    = 1'b1;
        mc_done_rd = RW'(mQ[0]);
      end else if (!legalOnly && ($urandom % 40) == 0) begin
        mc_done = 1'b1;
      end
      mc_issue    = ($urandom % 3) == 0;
      mc_issue_rd = RW'($urandom_range(0, 7));
      if (legalOnly && mInfl == MC && !mc_done) mc_issue = 1'b0;
      cycle();
    end
  endtask

  initial begin
    clearInputs();
    modelReset();
    rst_n = 1'b0;
    #12;
    checkVal("rst_pending", 64'(pending), 64'(0));
    checkVal("rst_inflight", 64'(mc_inflight), 64'(0));
    checkVal("rst_timeout", 64'(mc_timeout), 64'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Forward priority
    RdM = 5; RdW = 5; RegWriteM = 1; RegWriteW = 1; Rs1E = 5; Rs2E = 5;
    #1 checkVal("fwd_m", 64'(ForwardAE), 64'(2'b10));
    checkVal("fwd_b_m", 64'(ForwardBE), 64'(2'b10));
    RegWriteM = 0;
    #1 checkVal("fwd_w", 64'(ForwardAE), 64'(2'b01));
    Rs1E = 0;
    #1 checkVal("fwd_x0", 64'(ForwardAE), 64'(2'b00));
    cycle();
    clearInputs();

    // Load-use
    ResultSrcE_zero = 1; RdE = 7; Rs2D = 7;
    #1 checkVal("lu_stallF", 64'(StallF), 64'(1));
    checkVal("lu_flushE", 64'(FlushE), 64'(1));
    checkVal("lu_flushD", 64'(FlushD), 64'(0));
    cycle();
    RdE = 0; Rs2D = 0;
    #1 checkVal("lu_rd0", 64'(StallF), 64'(0));
    cycle();
    clearInputs();

    // Scoreboard RAW
    mc_issue = 1; mc_issue_rd = 9;
    cycle();
    mc_issue = 0; Rs1D = 9;
    #1 checkVal("raw_stall1", 64'(StallD), 64'(1));
    cycle();
    checkVal("raw_stall2", 64'(StallD), 64'(1));
    mc_done = 1; mc_done_rd = 9;
    cycle();
    mc_done = 0;
    #1 checkVal("raw_clear", 64'(pending[9]), 64'(0));
    checkVal("raw_nostall", 64'(StallD), 64'(0));
    cycle();
    clearInputs();

    // Same-cycle done/issue
    mc_issue = 1; mc_issue_rd = 3;
    cycle();
    mc_done = 1; mc_done_rd = 3;
    cycle();
    checkVal("same_p3", 64'(pending[3]), 64'(1));
    checkVal("same_infl", 64'(mc_inflight), 64'(1));
    mc_issue_rd = 4;
    cycle();
    checkVal("dist_p3", 64'(pending[3]), 64'(0));
    checkVal("dist_p4", 64'(pending[4]), 64'(1));
    mc_issue = 0; mc_done_rd = 4;
    cycle();
    clearInputs();

    // Structural
    mc_issue = 1; mc_issue_rd = 10;
    cycle();
    mc_issue = 0; mcD = 1;
    #1 checkVal("struct_stall", 64'(StallF), 64'(1));
    cycle();
    mc_done = 1; mc_done_rd = 10;
    #1 checkVal("struct_done", 64'(StallF), 64'(0));
    cycle();
    clearInputs();

    // Watchdog
    mc_issue = 1; mc_issue_rd = 11;
    cycle();
    mc_issue = 0;
    for (int i = 0; i < 7; i++) cycle();
    checkVal("wd_before", 64'(mc_timeout), 64'(0));
    cycle();
    checkVal("wd_fire", 64'(mc_timeout), 64'(1));
    mc_done = 1; mc_done_rd = 11;
    cycle();
    mc_done = 0;
    checkVal("wd_sticky", 64'(mc_timeout), 64'(1));
    #1 rst_n = 1'b0;
    #1 checkVal("async_to", 64'(mc_timeout), 64'(0));
    checkVal("async_pend", 64'(pending), 64'(0));
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    randomPhase(300, 1'b1);
    clearInputs();
    rst_n = 1'b0;
    #1 modelReset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    randomPhase(300, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
Parametrised successor to the current single-issue hazard logic. It keeps the classic forwarding, load-use stall and branch-flush functions, and adds a per-register pending scoreboard for variable-latency (multi-cycle) execute ops such as a divider. It also adds an outstanding-op watchdog. It sits beside the five-stage pipeline and drives the stall, flush and forward controls of the IF/ID/EX stages.

Parameters:
NREGS, 32, number of architectural registers; x0 is never pending or forwarded.
REGW, 5, register index width; must equal $clog2(NREGS).
MC_UNITS, 1, maximum number of multi-cycle ops in flight (1..4).
MAX_LAT, 64, watchdog limit in cycles for any outstanding multi-cycle op.
CNTW, $clog2(MAX_LAT+1), watchdog counter width (derived).

Ports:
clk  in  1  pipeline clock
rst_n  in  1  asynchronous active-low reset
Rs1D, Rs2D, RdD  in  REGW  decode-stage source/destination indices
mcD  in  1  decode instruction is a multi-cycle op
Rs1E, Rs2E, RdE  in  REGW  execute-stage indices
ResultSrcE_zero  in  1  EX instruction is a load (ResultSrc[0])
PCSrcE  in  1  taken branch/jump resolved in EX
RdM, RdW  in  REGW  memory/writeback destination indices
RegWriteM, RegWriteW  in  1  register write enables in M/W
mc_issue  in  1  multi-cycle op leaves EX into the unit this cycle
mc_issue_rd  in  REGW  its destination
mc_done  in  1  multi-cycle op writes back this cycle
mc_done_rd  in  REGW  its destination
StallF, StallD, FlushD, FlushE  out  1  pipeline controls
ForwardAE, ForwardBE  out  2  00 regfile, 10 from M, 01 from W
pending  out  NREGS  scoreboard bit vector (bit 0 tied 0)
mc_inflight  out  $clog2(MC_UNITS+1)  outstanding op count
mc_timeout  out  1  sticky watchdog error

Behaviour:
- Reset (rst_n low, async): pending=0, mc_inflight=0, watchdog counter=0, mc_timeout=0. Combinational outputs then follow the inputs, with the scoreboard empty.
- ForwardAE (combinational):
  - 10 if Rs1E==RdM & RegWriteM & Rs1E!=0;
  - else 01 if Rs1E==RdW & RegWriteW & Rs1E!=0;
  - else 00.
  - M has priority over W.
  - ForwardBE is identical with Rs2E.
- lwStall = ResultSrcE_zero & RdE!=0 & (Rs1D==RdE | Rs2D==RdE).
- sbStall: any of the following.
  - pending[Rs1D] or pending[Rs2D] (RAW).
  - pending[RdD] with RdD!=0 (WAW).
  - mcD & (mc_inflight==MC_UNITS) & !mc_done (structural).
- StallF = StallD = lwStall | sbStall.
- FlushD = PCSrcE.
- FlushE = lwStall | sbStall | PCSrcE.
- Scoreboard update (rising clk):
  - mc_done clears pending[mc_done_rd].
  - mc_issue with mc_issue_rd!=0 sets pending[mc_issue_rd].
  - Same register both events in one cycle: set wins (pending stays 1).
  - mc_issue with rd=0 still counts toward mc_inflight but sets no bit.
- mc_inflight: +1 on mc_issue, -1 on mc_done; simultaneous events leave it unchanged.
  - Saturates at 0 and MC_UNITS; under- or overflow attempts (protocol violation) set mc_timeout.
- Watchdog:
  - Counter increments each cycle while mc_inflight!=0.
  - Resets to 0 on mc_done or when mc_inflight==0.
  - On reaching MAX_LAT, mc_timeout is set. It is sticky until reset; the counter holds.
- Scoreboard bits are not affected by PCSrcE or the flushes. Ops already issued always complete.
- Reset asserted mid-operation clears all state immediately. Any later mc_done without a prior issue is a violation and sets mc_timeout.

Test Plan:
- Forward priority: RdM=RdW=5, RegWriteM=RegWriteW=1, Rs1E=5 -> ForwardAE=10. Drop RegWriteM -> 01. Rs1E=0 -> 00.
- Load-use: ResultSrcE_zero=1, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1, FlushD=0 for exactly that cycle. With RdE=0 -> no stall.
- Scoreboard RAW: mc_issue rd=9; next cycle Rs1D=9 -> stall each cycle. mc_done rd=9 at cycle N -> pending[9]=0 at N+1, stall drops.
- Same-cycle done/issue on rd=3 -> pending[3] stays 1, mc_inflight unchanged. Distinct rds 3 (done) and 4 (issue) -> pending[3]=0, pending[4]=1.
- Structural (MC_UNITS=1): inflight=1, mcD=1 -> stall. Same cycle with mc_done=1 -> no stall.
- Watchdog (MAX_LAT=8): issue, no done -> mc_timeout=1 exactly 8 cycles later and stays 1 after a later done. Async rst_n low clears it without a clock edge.
